queue_ctrl_4x4b: RTL and testbench
==================================

Name: queue_ctrl_4x4b

Overview:
Control unit for a 4-entry, 4-bit-wide FIFO queue built around a flat 1-read/1-write 4x4b register file.
- Accepts producer items on a val/rdy enqueue interface and presents them in order on a val/rdy dequeue interface.
- Drives the regfile write-enable, write-address and read-address ports.
- Data never passes through this block: enq data wires straight to regfile wdata; regfile rdata (combinational read) wires straight to deq data.
- Sits directly upstream of the regfile as its sole write/read-address source.

Parameters:
None. Depth is fixed at 4 entries and the address width at 2 bits, matching the 4x4b storage.

Ports:
clk       input   1  clock; all state updates on posedge
rst       input   1  synchronous, active-high reset
enq_val   input   1  producer has an item (data on regfile wdata)
enq_rdy   output  1  queue can accept an item this cycle
deq_val   output  1  queue head is valid (data on regfile rdata)
deq_rdy   input   1  consumer accepts head this cycle
rf_wen    output  1  regfile write enable
rf_waddr  output  2  regfile write address (= write pointer)
rf_raddr  output  2  regfile read address (= read pointer)
count     output  3  number of occupied entries, 0..4

Behaviour:
- The interface is decided: one clock (clk) and a synchronous, active-high reset (rst).
- State:
  - wptr[1:0], rptr[1:0], cnt[2:0]
  - count = cnt; rf_waddr = wptr; rf_raddr = rptr
- Reset: while rst=1, every posedge sets wptr=0, rptr=0, cnt=0. During rst=1:
  - enq_rdy=0, deq_val=0, rf_wen=0 (combinationally forced)
  - count=0 after the first reset edge
- After reset deasserts, the first cycle shows enq_rdy=1, deq_val=0, count=0.
- Status flags:
  - empty = (cnt==0); full = (cnt==4)
  - enq_rdy = !rst & !full
  - deq_val = !rst & !empty
- Transfers: enq_fire = enq_val & enq_rdy; deq_fire = deq_val & deq_rdy.
- enq_rdy does not depend on deq_rdy, and deq_val does not depend on enq_val. There are no combinational val->rdy paths.
- rf_wen = enq_fire. The regfile captures wdata at the same posedge the pointer advances.
- On posedge with rst=0:
  - enq_fire: wptr <= wptr+1 (mod 4)
  - deq_fire: rptr <= rptr+1 (mod 4)
  - cnt: +1 if enq only, -1 if deq only, unchanged if both or neither
- No bypass:
  - An item enqueued at cycle t is first visible on deq at cycle t+1 (1-cycle minimum latency).
  - Enqueue into an empty queue never produces deq_val in the same cycle.
- Full: enq_rdy=0 even if deq_fire occurs that cycle. The slot reopens the following cycle.
- Simultaneous enq_fire and deq_fire with cnt in 1..3: both pointers advance, cnt holds. At cnt=1 this is legal because write and read addresses differ.
- Pointer wrap: 3->0 on both pointers. Ordering is preserved across wrap.
- Reset mid-operation: all queued items are discarded (pointers and count return to 0). Stale regfile contents are unreachable because deq_val=0.
- enq_val when not ready and deq_rdy when not valid are ignored: no state change, rf_wen=0.
- Invariants (assertion-checked in the bench):
  - cnt<=4
  - cnt==0 implies wptr==rptr
  - cnt==4 implies wptr==rptr

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles with enq_val=1, deq_rdy=1.
  - Response: enq_rdy=0, deq_val=0, rf_wen=0 throughout. After release: count=0, enq_rdy=1.
- Fill to full:
  - Stimulus: enqueue 0xA, 0xB, 0xC, 0xD on consecutive cycles with deq_rdy=0.
  - Response: rf_waddr 0,1,2,3 with rf_wen=1; count 1..4; enq_rdy=0 on the cycle after the 4th; 5th enq_val ignored (rf_wen=0).
- Drain in order:
  - Stimulus: from full, deq_rdy=1 for 4 cycles.
  - Response: rf_raddr 0,1,2,3, deq data 0xA, 0xB, 0xC, 0xD; count 3..0; deq_val=0 afterwards.
- Streaming with wrap:
  - Stimulus: enq_val=1 and deq_rdy=1 continuously for 10 items, values 0..9.
  - Response: first deq_val one cycle after first enq; count stays 1; pointers wrap 3->0; output sequence 0..9.
- Full and dequeue same cycle:
  - Stimulus: full queue, enq_val=1, deq_rdy=1.
  - Response: only deq fires, count 4->3; next cycle enq_rdy=1 and enq fires, count back to 4.
- Reset mid-stream:
  - Stimulus: with count=2 (wptr=2, rptr=0), pulse rst for 1 cycle.
  - Response: count=0, deq_val=0, rf_waddr=0, rf_raddr=0; the next enqueued item is dequeued first.

Source files
------------

// File: rtl/queue_ctrl_4x4b.sv
// -----------------------------------------------------------------------------
// queue_ctrl_4x4b
//
// Control unit for a 4-entry x 4-bit FIFO built around an external flat
// 1R/1W register file. This block owns the write pointer, read pointer and
// occupancy count. Data never passes through here: the producer's data is
// wired straight to the regfile wdata, and the regfile's combinational read
// data is wired straight to the consumer.
//
// Ports:
//   clk       in   1  clock, all state updates on posedge
//   rst       in   1  synchronous, active-high reset
//   enq_val   in   1  producer has an item (data presented on regfile wdata)
//   enq_rdy   out  1  queue can accept an item this cycle
//   deq_val   out  1  queue head valid (data presented on regfile rdata)
//   deq_rdy   in   1  consumer accepts the head this cycle
//   rf_wen    out  1  regfile write enable (= enqueue transfer)
//   rf_waddr  out  2  regfile write address (= write pointer)
//   rf_raddr  out  2  regfile read address (= read pointer)
//   count     out  3  occupied entries, 0..4
//
// Handshake: a transfer happens on a posedge where val and rdy are both high.
// rdy never depends on the same side's val, and neither side's flag depends
// on the other side's handshake input, so there is no combinational path
// from any val/rdy input to any val/rdy output. There is no bypass: an item
// written at cycle t first appears on the dequeue side at cycle t+1, and a
// full queue refuses enqueue even when a dequeue happens in the same cycle.
// -----------------------------------------------------------------------------
module queue_ctrl_4x4b (
    input  logic       clk,
    input  logic       rst,
    input  logic       enq_val,
    output logic       enq_rdy,
    output logic       deq_val,
    input  logic       deq_rdy,
    output logic       rf_wen,
    output logic [1:0] rf_waddr,
    output logic [1:0] rf_raddr,
    output logic [2:0] count
);

    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_cnt;

    logic       w_empty;
    logic       w_full;
    logic       w_enq_fire;
    logic       w_deq_fire;

    assign w_empty = (r_cnt == 3'd0);
    assign w_full  = (r_cnt == 3'd4);

    // Flags are gated by rst so nothing can fire while reset is held, even
    // before the first reset edge has cleared the registers.
    assign enq_rdy = !rst && !w_full;
    assign deq_val = !rst && !w_empty;

    assign w_enq_fire = enq_val && enq_rdy;
    assign w_deq_fire = deq_val && deq_rdy;

    assign rf_wen   = w_enq_fire;
    assign rf_waddr = r_wptr;
    assign rf_raddr = r_rptr;
    assign count    = r_cnt;

    // Two-bit pointers wrap 3->0 naturally. Because full and empty both have
    // wptr==rptr, the separate count register disambiguates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
            r_cnt  <= 3'd0;
        end else begin
            if (w_enq_fire) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_deq_fire) begin
                r_rptr <= r_rptr + 2'd1;
            end
            if (w_enq_fire && !w_deq_fire) begin
                r_cnt <= r_cnt + 3'd1;
            end else if (w_deq_fire && !w_enq_fire) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_queue_ctrl_4x4b.sv
// -----------------------------------------------------------------------------
// tb_queue_ctrl_4x4b
//
// Bench for queue_ctrl_4x4b. A small regfile is modelled here so the data
// path can be observed end to end. The reference is a plain queue of items
// plus enqueue/dequeue counters; every step checks handshake flags, count,
// addresses, head data and the pointer invariants against that reference.
// -----------------------------------------------------------------------------
module tb_queue_ctrl_4x4b;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic       enq_val;
    logic       enq_rdy;
    logic       deq_val;
    logic       deq_rdy;
    logic       rf_wen;
    logic [1:0] rf_waddr;
    logic [1:0] rf_raddr;
    logic [2:0] count;
    logic [3:0] wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    queue_ctrl_4x4b dut (
        .clk      (clk),
        .rst      (rst),
        .enq_val  (enq_val),
        .enq_rdy  (enq_rdy),
        .deq_val  (deq_val),
        .deq_rdy  (deq_rdy),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_raddr (rf_raddr),
        .count    (count)
    );

    // Regfile attached to the controller's address/enable ports.
    logic [3:0] mem [4];
    always @(posedge clk) begin
        if (rf_wen) mem[rf_waddr] <= wdata;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [3:0] exp_q[$];
    int         n_enq;
    int         n_deq;
    bit         model_known;

    int passed;
    int total;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock step: drive inputs, check combinational outputs mid-cycle,
    // then advance the reference model at the posedge.
    task automatic step(input logic ev, input logic [3:0] wd, input logic dr, input logic rs);
        logic exp_rdy;
        logic exp_val;
        logic ef;
        logic df;
        enq_val = ev;
        wdata   = wd;
        deq_rdy = dr;
        rst     = rs;
        #1;
        exp_rdy = !rs && (exp_q.size() < 4);
        exp_val = !rs && (exp_q.size() > 0);
        ef = ev && exp_rdy;
        df = dr && exp_val;
        chk("enq_rdy", {7'd0, enq_rdy}, {7'd0, exp_rdy});
        chk("deq_val", {7'd0, deq_val}, {7'd0, exp_val});
        chk("rf_wen",  {7'd0, rf_wen},  {7'd0, ef});
        if (model_known) begin
            chk("count",    {5'd0, count},    8'(exp_q.size()));
            chk("rf_waddr", {6'd0, rf_waddr}, 8'(n_enq % 4));
            chk("rf_raddr", {6'd0, rf_raddr}, 8'(n_deq % 4));
            chk("inv_cnt_le4", {7'd0, (count <= 3'd4)}, 8'd1);
            chk("inv_ptr_eq", {7'd0, ((count != 3'd0 && count != 3'd4) || rf_waddr == rf_raddr)}, 8'd1);
        end
        if (exp_val) begin
            chk("deq_data", {4'd0, mem[rf_raddr]}, {4'd0, exp_q[0]});
        end
        @(posedge clk);
        if (rs) begin
            exp_q.delete();
            n_enq = 0;
            n_deq = 0;
            model_known = 1'b1;
        end else begin
            if (df) begin
                void'(exp_q.pop_front());
                n_deq++;
            end
            if (ef) begin
                exp_q.push_back(wd);
                n_enq++;
            end
        end
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        passed = 0;
        total = 0;
        n_enq = 0;
        n_deq = 0;
        model_known = 1'b0;
        enq_val = 1'b0;
        deq_rdy = 1'b0;
        wdata = 4'd0;
        rst = 1'b1;

        // Reset with both sides requesting; nothing may fire.
        step(1'b1, 4'h3, 1'b1, 1'b1);
        step(1'b1, 4'h3, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0);

        // Fill to full, then a fifth enqueue is refused.
        step(1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b1, 4'hB, 1'b0, 1'b0);
        step(1'b1, 4'hC, 1'b0, 1'b0);
        step(1'b1, 4'hD, 1'b0, 1'b0);
        step(1'b1, 4'hE, 1'b0, 1'b0);

        // Drain in order, then idle empty.
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        // Streaming with pointer wrap.
        for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        // Full with simultaneous dequeue: only dequeue fires, slot reopens next.
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 4), 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b1, 1'b0);
        step(1'b1, 4'h6, 1'b0, 1'b0);
        step(1'b1, 4'h7, 1'b0, 1'b0);

        // Reset mid-stream with two items queued.
        for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'h1, 1'b0, 1'b0);
        step(1'b1, 4'h2, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b1, 4'h8, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
